// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and width constants for the round controller
package game_pkg;

    localparam int ROUND_W = 4;
    localparam int TICK_W  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        SCORE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/round_timer.sv
// rtl/round_timer.sv - loadable down-counter with zero flag; saturates at zero
module round_timer
    import game_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_load,
    input  logic [TICK_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic [TICK_W-1:0] o_count,
    output logic              o_zero
);

    logic [TICK_W-1:0] r_count;
    logic              w_zero;

    assign w_zero  = (r_count == '0);
    assign o_count = r_count;
    assign o_zero  = w_zero;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && !w_zero) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/round_controller.sv
// rtl/round_controller.sv - game round FSM; round timeout built only with ROUND_CONTROLLER_TIMEOUT_EN
module round_controller
    import game_pkg::*;
#(
    parameter int ROUND_TICKS = 200,
    parameter int MAX_ROUNDS  = 9
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Allow,
    input  logic               Start,
    input  logic               Stop,
    input  logic               SubA,
    input  logic               SubB,
    input  logic               MatchA,
    input  logic               MatchB,
    output logic               LoadRNG,
    output logic               EnA,
    output logic               EnB,
    output logic               PointA,
    output logic               PointB,
    output logic [ROUND_W-1:0] Round,
    output logic [TICK_W-1:0]  TimeLeft,
    output logic               GameOver
);

    localparam logic [ROUND_W-1:0] MAX_R = ROUND_W'(MAX_ROUNDS);

    if (ROUND_TICKS < 2 || ROUND_TICKS > 255 || MAX_ROUNDS < 1 || MAX_ROUNDS > 15) begin : g_bad_param
        $error("round_controller: parameter out of range");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ROUND_W-1:0] r_round;
    logic               r_lock_a;
    logic               r_lock_b;
    logic               r_win_a;
    logic               r_win_b;

    logic w_abort;
    logic w_start;
    logic w_sub_a;
    logic w_sub_b;
    logic w_win_a;
    logic w_win_b;
    logic w_lock_a_nxt;
    logic w_lock_b_nxt;
    logic w_timeout;

    assign w_start      = Start && Allow;
    assign w_sub_a      = SubA && !r_lock_a;
    assign w_sub_b      = SubB && !r_lock_b;
    assign w_win_a      = w_sub_a && MatchA;
    assign w_win_b      = w_sub_b && MatchB;
    assign w_lock_a_nxt = r_lock_a || (w_sub_a && !MatchA);
    assign w_lock_b_nxt = r_lock_b || (w_sub_b && !MatchB);

    // Losing Allow mid-game is an abort; in DONE only Stop blocks a restart.
    assign w_abort = ((r_state == LOAD || r_state == PLAY || r_state == SCORE) && (Stop || !Allow))
                   || (r_state == DONE && Stop);

`ifdef ROUND_CONTROLLER_TIMEOUT_EN
    localparam logic [TICK_W-1:0] TICKS = TICK_W'(ROUND_TICKS);

    logic [TICK_W-1:0] w_time_left;
    logic              w_timer_zero;

    round_timer u_round_timer (
        .i_clk      (Clk),
        .i_rstn     (Rst),
        .i_load     (r_state == LOAD && w_state_nxt == PLAY),
        .i_load_val (TICKS),
        .i_dec      (r_state == PLAY),
        .o_count    (w_time_left),
        .o_zero     (w_timer_zero)
    );

    assign TimeLeft  = w_time_left;
    assign w_timeout = (w_time_left == TICK_W'(1)) || w_timer_zero;
`else
    assign TimeLeft  = '0;
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        LoadRNG     = 1'b0;
        EnA         = 1'b0;
        EnB         = 1'b0;
        PointA      = 1'b0;
        PointB      = 1'b0;
        GameOver    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_state_nxt = LOAD;
            end
            LOAD: begin
                LoadRNG     = 1'b1;
                w_state_nxt = w_abort ? DONE : PLAY;
            end
            PLAY: begin
                EnA = !r_lock_a;
                EnB = !r_lock_b;
                if (w_abort) begin
                    w_state_nxt = DONE;
                end else if (w_win_a || w_win_b || (w_lock_a_nxt && w_lock_b_nxt) || w_timeout) begin
                    w_state_nxt = SCORE;
                end
            end
            SCORE: begin
                PointA = r_win_a && !w_abort;
                PointB = r_win_b && !w_abort;
                if (w_abort || r_round >= MAX_R) w_state_nxt = DONE;
                else                             w_state_nxt = LOAD;
            end
            DONE: begin
                GameOver = 1'b1;
                if (!Stop && w_start) w_state_nxt = LOAD;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state  <= IDLE;
            r_round  <= '0;
            r_lock_a <= 1'b0;
            r_lock_b <= 1'b0;
            r_win_a  <= 1'b0;
            r_win_b  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == LOAD) begin
                r_round <= (r_state == SCORE) ? r_round + 1'b1 : ROUND_W'(1);
            end
            if (r_state == LOAD) begin
                r_lock_a <= 1'b0;
                r_lock_b <= 1'b0;
            end else if (r_state == PLAY) begin
                r_lock_a <= w_lock_a_nxt;
                r_lock_b <= w_lock_b_nxt;
            end
            // A tie scores nobody; winners only live through the single SCORE cycle.
            r_win_a <= (r_state == PLAY) && (w_state_nxt == SCORE) && w_win_a && !w_win_b;
            r_win_b <= (r_state == PLAY) && (w_state_nxt == SCORE) && w_win_b && !w_win_a;
        end
    end

    assign Round = r_round;

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - directed self-checking bench for round_controller (MAX_ROUNDS=2)
module tb_round_controller;

    logic       Clk = 1'b0;
    logic       Rst, Allow, Start, Stop, SubA, SubB, MatchA, MatchB;
    logic       LoadRNG, EnA, EnB, PointA, PointB, GameOver;
    logic [3:0] Round;
    logic [7:0] TimeLeft;

    int checks = 0;
    int errors = 0;
    int pa_cnt = 0;
    int pb_cnt = 0;

`ifdef ROUND_CONTROLLER_TIMEOUT_EN
    localparam int EXP_TL   = 200;
    localparam int EXP_HOLD = 196;
`else
    localparam int EXP_TL   = 0;
    localparam int EXP_HOLD = 0;
`endif

    always #5 Clk = ~Clk;

    round_controller #(.ROUND_TICKS(200), .MAX_ROUNDS(2)) dut (
        .Clk(Clk), .Rst(Rst), .Allow(Allow), .Start(Start), .Stop(Stop),
        .SubA(SubA), .SubB(SubB), .MatchA(MatchA), .MatchB(MatchB),
        .LoadRNG(LoadRNG), .EnA(EnA), .EnB(EnB), .PointA(PointA), .PointB(PointB),
        .Round(Round), .TimeLeft(TimeLeft), .GameOver(GameOver)
    );

    always @(negedge Clk) begin
        if (PointA === 1'b1) pa_cnt++;
        if (PointB === 1'b1) pb_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_subs();
        SubA = 0; SubB = 0; MatchA = 0; MatchB = 0;
    endtask

    initial begin
        Rst = 0; Allow = 0; Start = 0; Stop = 0;
        clear_subs();
        step(2);
        check("rst_flags", {LoadRNG, EnA, EnB, PointA, PointB, GameOver}, 0);
        check("rst_round", Round, 0);
        check("rst_time", TimeLeft, 0);

        Rst = 1; Start = 1; Allow = 0;
        step();
        check("start_no_allow", {LoadRNG, Round}, 0);

        Allow = 1;
        step();
        Start = 0;
        check("load_rng", LoadRNG, 1);
        check("load_round", Round, 1);
        check("load_en", {EnA, EnB}, 0);
        step();
        check("play_rng", LoadRNG, 0);
        check("play_en", {EnA, EnB}, 2'b11);
        check("play_time", TimeLeft, EXP_TL);

        SubA = 1; SubB = 1; MatchA = 1; MatchB = 1;
        step();
        clear_subs();
        check("tie_score_en", {EnA, EnB}, 0);
        check("tie_no_point", {PointA, PointB}, 0);
        step();
        check("tie_round2", Round, 2);
        check("tie_load", LoadRNG, 1);
        step();

        SubA = 1; MatchA = 0;
        step();
        clear_subs();
        check("lock_a_en", {EnA, EnB}, 2'b01);
        step(2);
        SubB = 1; MatchB = 1;
        step();
        clear_subs();
        check("b_point", {PointA, PointB}, 2'b01);
        step();
        check("done_over", GameOver, 1);
        check("done_round", Round, 2);
        step(3);
        check("done_hold", {GameOver, Round}, {1'b1, 4'd2});
        check("done_time_hold", TimeLeft, EXP_HOLD);
        check("cnt_after_g1", {pa_cnt[7:0], pb_cnt[7:0]}, {8'd0, 8'd1});

        Start = 1;
        step();
        Start = 0;
        check("g2_restart", {GameOver, Round}, {1'b0, 4'd1});
        step();
`ifdef ROUND_CONTROLLER_TIMEOUT_EN
        step(199);
        check("to_last_tick", {EnA, TimeLeft}, {1'b1, 8'd1});
        step();
        check("to_score", {EnA, PointA, PointB, TimeLeft}, 0);
        step();
        check("to_round2", Round, 2);
        step();
        check("to_reload", TimeLeft, 200);
`else
        step(210);
        check("nt_still_play", {EnA, TimeLeft, Round}, {1'b1, 8'd0, 4'd1});
        SubA = 1; MatchA = 0; SubB = 1; MatchB = 0;
        step();
        clear_subs();
        check("nt_both_lock", {EnA, EnB, PointA, PointB}, 0);
        step();
        check("nt_round2", Round, 2);
        step();
`endif
        SubA = 1; MatchA = 0;
        step();
        clear_subs();
        step();
        check("stag_lock_a", {EnA, EnB}, 2'b01);
        SubB = 1; MatchB = 0;
        step();
        clear_subs();
        check("stag_score", {EnA, EnB, PointA, PointB}, 0);
        step();
        check("g2_done", GameOver, 1);
        check("cnt_after_g2", {pa_cnt[7:0], pb_cnt[7:0]}, {8'd0, 8'd1});

        Start = 1;
        step();
        Start = 0;
        step();
        SubA = 1; MatchA = 1;
        step();
        clear_subs();
        check("g3_r1_point", {PointA, PointB}, 2'b10);
        step(2);
        SubA = 1; MatchA = 1;
        step();
        clear_subs();
        check("g3_r2_point", {PointA, PointB}, 2'b10);
        step();
        check("g3_done", {GameOver, Round}, {1'b1, 4'd2});
        step(4);
        check("g3_hold", {GameOver, Round}, {1'b1, 4'd2});
        check("cnt_after_g3", pa_cnt, 2);

        Start = 1;
        step();
        Start = 0;
        check("g4_restart", {GameOver, Round, LoadRNG}, {1'b0, 4'd1, 1'b1});
        step();
        Stop = 1; SubA = 1; MatchA = 1;
        step();
        clear_subs();
        check("stop_done", {GameOver, PointA, Round}, {1'b1, 1'b0, 4'd1});
        Stop = 0;
        step();
        check("stop_no_pa", pa_cnt, 2);

        Start = 1;
        step();
        Start = 0;
        step();
        Allow = 0;
        step();
        check("allow_drop", {GameOver, EnA, EnB}, 3'b100);
        Allow = 1;

        Start = 1;
        step();
        Start = 0;
        step();
        SubB = 1; MatchB = 1;
        step();
        clear_subs();
        Stop = 1;
        #1;
        check("score_stop_pb", PointB, 0);
        step();
        Stop = 0;
        check("score_stop_done", GameOver, 1);
        check("score_stop_cnt", pb_cnt, 1);

        Start = 1;
        step();
        Start = 0;
        step();
        check("pre_rst_play", EnA, 1);
        Rst = 0;
        step();
        check("mid_rst_flags", {LoadRNG, EnA, EnB, PointA, PointB, GameOver}, 0);
        check("mid_rst_cnt", {Round, TimeLeft}, 0);
        Rst = 1;
        step();
        check("post_rst_idle", {LoadRNG, GameOver, Round}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
